// File: rtl/base_hold_for_n_mc_pkg.sv
// Shared constants for the multi-channel pulse stretcher.
// Only the per-channel state width lives here.
package base_hold_for_n_mc_pkg;
    localparam int unsigned HOLD_STATE_W = 2;
endpackage

// File: rtl/base_hold_for_n_ch.sv
// One pulse-stretcher channel: IDLE -> HOLD (i_n cycles) -> optional GAP (i_gap cycles).
// Outputs are registered one stage behind the state, so a trigger at edge k shows on o_d from edge k+1.
module base_hold_for_n_ch
    import base_hold_for_n_mc_pkg::*;
#(
    parameter int cwidth = 8,
    parameter bit retrig = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_d,
    input  logic              i_clr,
    input  logic [cwidth-1:0] i_n,
    input  logic [cwidth-1:0] i_gap,
    output logic              o_d,
    output logic              o_busy,
    output logic              o_done
);
    typedef enum logic [HOLD_STATE_W-1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic [cwidth-1:0] cnt, cnt_nxt;
    logic [cwidth-1:0] gcnt, gcnt_nxt;
    logic              d_nxt, busy_nxt, done_nxt;
    logic              trig;

    // A zero-length hold request is not a trigger at all.
    assign trig = i_d && (i_n != '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        gcnt_nxt  = gcnt;
        d_nxt     = 1'b0;
        busy_nxt  = 1'b0;
        done_nxt  = 1'b0;
        if (i_clr) begin
            state_nxt = ST_IDLE;
            cnt_nxt   = '0;
            gcnt_nxt  = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (trig) begin
                        state_nxt = ST_HOLD;
                        cnt_nxt   = i_n - cwidth'(1);
                    end
                end
                ST_HOLD: begin
                    d_nxt    = 1'b1;
                    busy_nxt = 1'b1;
                    if (retrig && trig) begin
                        cnt_nxt = i_n - cwidth'(1);
                    end else if (cnt == '0) begin
                        done_nxt = 1'b1;
                        if (i_gap != '0) begin
                            state_nxt = ST_GAP;
                            gcnt_nxt  = i_gap - cwidth'(1);
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        cnt_nxt = cnt - cwidth'(1);
                    end
                end
                ST_GAP: begin
                    busy_nxt = 1'b1;
                    if (gcnt == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        gcnt_nxt = gcnt - cwidth'(1);
                    end
                end
                default: begin
                    state_nxt = ST_IDLE;
                    cnt_nxt   = '0;
                    gcnt_nxt  = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            gcnt   <= '0;
            o_d    <= 1'b0;
            o_busy <= 1'b0;
            o_done <= 1'b0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            gcnt   <= gcnt_nxt;
            o_d    <= d_nxt;
            o_busy <= busy_nxt;
            o_done <= done_nxt;
        end
    end
endmodule

// File: rtl/base_hold_for_n_mc.sv
// Multi-channel programmable pulse stretcher with optional retrigger and lockout gap.
// Every channel is an independent instance sharing the hold and gap lengths.
module base_hold_for_n_mc
    import base_hold_for_n_mc_pkg::*;
#(
    parameter int channels = 4,
    parameter int cwidth   = 8,
    parameter bit retrig   = 1'b1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [channels-1:0] i_d,
    input  logic [channels-1:0] i_clr,
    input  logic [cwidth-1:0]   i_n,
    input  logic [cwidth-1:0]   i_gap,
    output logic [channels-1:0] o_d,
    output logic [channels-1:0] o_busy,
    output logic [channels-1:0] o_done
);
    for (genvar g = 0; g < channels; g++) begin : g_ch
        base_hold_for_n_ch #(
            .cwidth(cwidth),
            .retrig(retrig)
        ) u_ch (
            .clk   (clk),
            .reset (reset),
            .i_d   (i_d[g]),
            .i_clr (i_clr[g]),
            .i_n   (i_n),
            .i_gap (i_gap),
            .o_d   (o_d[g]),
            .o_busy(o_busy[g]),
            .o_done(o_done[g])
        );
    end
endmodule

// File: tb/tb_base_hold_for_n_mc.sv
// Bench for base_hold_for_n_mc: a retrigger and a non-retrigger instance share stimulus
// and are compared against a cycles-remaining reference model, directed tables and hand sequences.
module tb_base_hold_for_n_mc;
    localparam int CH = 4;
    localparam int CW = 8;
    localparam int EW = 3 * CH;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [CH-1:0] i_d, i_clr;
    logic [CW-1:0] i_n, i_gap;
    logic [CH-1:0] o_d1, o_busy1, o_done1;
    logic [CH-1:0] o_d0, o_busy0, o_done0;

    base_hold_for_n_mc #(.channels(CH), .cwidth(CW), .retrig(1'b1)) dut_r1 (
        .clk(clk), .reset(reset), .i_d(i_d), .i_clr(i_clr), .i_n(i_n), .i_gap(i_gap),
        .o_d(o_d1), .o_busy(o_busy1), .o_done(o_done1)
    );
    base_hold_for_n_mc #(.channels(CH), .cwidth(CW), .retrig(1'b0)) dut_r0 (
        .clk(clk), .reset(reset), .i_d(i_d), .i_clr(i_clr), .i_n(i_n), .i_gap(i_gap),
        .o_d(o_d0), .o_busy(o_busy0), .o_done(o_done0)
    );

    // ---------------- reference model ----------------
    // hold_left: o_d-high cycles still owed; gap_left: lockout cycles still owed.
    int hold_left [2][CH];
    int gap_left  [2][CH];

    task automatic model_edge(input int m, output logic [EW-1:0] e);
        logic [CH-1:0] od, ob, odn;
        logic          trig;
        od = '0; ob = '0; odn = '0;
        for (int c = 0; c < CH; c++) begin
            trig = i_d[c] && (i_n != 0);
            if (reset || i_clr[c]) begin
                hold_left[m][c] = 0;
                gap_left[m][c]  = 0;
            end else begin
                od[c] = hold_left[m][c] > 0;
                ob[c] = (hold_left[m][c] > 0) || (gap_left[m][c] > 0);
                if (hold_left[m][c] > 0) begin
                    if (m == 1 && trig) begin
                        hold_left[m][c] = int'(i_n);
                    end else begin
                        hold_left[m][c] = hold_left[m][c] - 1;
                        if (hold_left[m][c] == 0) begin
                            odn[c] = 1'b1;
                            gap_left[m][c] = int'(i_gap);
                        end
                    end
                end else if (gap_left[m][c] > 0) begin
                    gap_left[m][c] = gap_left[m][c] - 1;
                end else if (trig) begin
                    hold_left[m][c] = int'(i_n);
                end
            end
        end
        e = {od, ob, odn};
    endtask

    // ---------------- scoreboard ----------------
    logic [2*EW-1:0] exp_q[$];
    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [EW-1:0] act, input logic [EW-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- driver ----------------
    task automatic step(input logic [CH-1:0] d, input logic [CH-1:0] clr,
                        input logic [CW-1:0] n, input logic [CW-1:0] gap, input logic rst);
        logic [EW-1:0]   e1, e0;
        logic [2*EW-1:0] sb;
        i_d = d; i_clr = clr; i_n = n; i_gap = gap; reset = rst;
        model_edge(1, e1);
        model_edge(0, e0);
        exp_q.push_back({e1, e0});
        @(posedge clk);
        #1;
        sb = exp_q.pop_front();
        check("model_r1", {o_d1, o_busy1, o_done1}, sb[2*EW-1:EW]);
        check("model_r0", {o_d0, o_busy0, o_done0}, sb[EW-1:0]);
    endtask

    // ---------------- directed table (channel 0) ----------------
    typedef struct {
        logic          d;
        logic          clr;
        logic [CW-1:0] n;
        logic [CW-1:0] gap;
        logic [2:0]    e1;   // {o_d, o_busy, o_done} for retrig=1
        logic [2:0]    e0;   // same for retrig=0
    } vec_t;
    vec_t tbl[$];

    function automatic void add(input logic d, input logic clr, input int n, input int gap,
                                input logic [2:0] e1, input logic [2:0] e0);
        vec_t v;
        v.d = d; v.clr = clr; v.n = CW'(n); v.gap = CW'(gap); v.e1 = e1; v.e0 = e0;
        tbl.push_back(v);
    endfunction

    function automatic logic [EW-1:0] ch0_vec(input logic [2:0] e);
        return {3'b000, e[2], 3'b000, e[1], 3'b000, e[0]};
    endfunction

    int cnt_hi1 [CH];
    int cnt_hi0 [CH];
    int dn1, dn0;
    logic [CH-1:0] rd, rc;
    logic [CW-1:0] rn, rg;

    initial begin
        i_d = '0; i_clr = '0; i_n = '0; i_gap = '0; reset = 1'b1;
        for (int m = 0; m < 2; m++)
            for (int c = 0; c < CH; c++) begin
                hold_left[m][c] = 0;
                gap_left[m][c]  = 0;
            end

        step('0, '0, 8'd0, 8'd0, 1'b1);
        step('0, '0, 8'd0, 8'd0, 1'b1);
        check("reset_state_r1", {o_d1, o_busy1, o_done1}, '0);
        check("reset_state_r0", {o_d0, o_busy0, o_done0}, '0);

        // basic hold n=3
        add(1,0,3,0,3'b000,3'b000); add(0,0,3,0,3'b110,3'b110); add(0,0,3,0,3'b110,3'b110);
        add(0,0,3,0,3'b111,3'b111); add(0,0,3,0,3'b000,3'b000);
        // retrigger n=4, triggers at k and k+2
        add(1,0,4,0,3'b000,3'b000); add(0,0,4,0,3'b110,3'b110); add(1,0,4,0,3'b110,3'b110);
        add(0,0,4,0,3'b110,3'b110); add(0,0,4,0,3'b110,3'b111); add(0,0,4,0,3'b110,3'b000);
        add(0,0,4,0,3'b111,3'b000); add(0,0,4,0,3'b000,3'b000);
        // gap lockout n=2 gap=3, i_d held high, then drained
        add(1,0,2,3,3'b000,3'b000); add(1,0,2,3,3'b110,3'b110); add(1,0,2,3,3'b110,3'b111);
        add(1,0,2,3,3'b110,3'b010); add(1,0,2,3,3'b110,3'b010); add(1,0,2,3,3'b110,3'b010);
        add(1,0,2,3,3'b110,3'b000); add(1,0,2,3,3'b110,3'b110); add(1,0,2,3,3'b110,3'b111);
        add(1,0,2,3,3'b110,3'b010); add(1,0,2,3,3'b110,3'b010); add(1,0,2,3,3'b110,3'b010);
        add(1,0,2,3,3'b110,3'b000);
        add(0,0,2,3,3'b110,3'b110); add(0,0,2,3,3'b111,3'b111); add(0,0,2,3,3'b010,3'b010);
        add(0,0,2,3,3'b010,3'b010); add(0,0,2,3,3'b010,3'b010); add(0,0,2,3,3'b000,3'b000);
        // back-to-back n=2 gap=0: exit cycle ignores i_d (retrig=0)
        add(1,0,2,0,3'b000,3'b000); add(1,0,2,0,3'b110,3'b110); add(1,0,2,0,3'b110,3'b111);
        add(1,0,2,0,3'b110,3'b000); add(1,0,2,0,3'b110,3'b110); add(0,0,2,0,3'b110,3'b111);
        add(0,0,2,0,3'b111,3'b000); add(0,0,2,0,3'b000,3'b000);
        // zero length
        add(1,0,0,0,3'b000,3'b000); add(1,0,0,0,3'b000,3'b000); add(0,0,0,0,3'b000,3'b000);
        // abort with simultaneous trigger during HOLD
        add(1,0,5,2,3'b000,3'b000); add(0,0,5,2,3'b110,3'b110); add(1,1,5,2,3'b000,3'b000);
        add(0,0,5,2,3'b000,3'b000);
        // abort during GAP
        add(1,0,1,3,3'b000,3'b000); add(0,0,1,3,3'b111,3'b111); add(0,0,1,3,3'b010,3'b010);
        add(0,1,1,3,3'b000,3'b000); add(0,0,1,3,3'b000,3'b000);

        for (int i = 0; i < tbl.size(); i++) begin
            step({3'b000, tbl[i].d}, {3'b000, tbl[i].clr}, tbl[i].n, tbl[i].gap, 1'b0);
            check($sformatf("tbl%0d_r1", i), {o_d1, o_busy1, o_done1}, ch0_vec(tbl[i].e1));
            check($sformatf("tbl%0d_r0", i), {o_d0, o_busy0, o_done0}, ch0_vec(tbl[i].e0));
        end

        // max length: n=255 on channel 1
        dn1 = 0; dn0 = 0;
        for (int c = 0; c < CH; c++) begin cnt_hi1[c] = 0; cnt_hi0[c] = 0; end
        step(4'b0010, '0, 8'd255, 8'd0, 1'b0);
        for (int i = 0; i < 270; i++) begin
            step('0, '0, 8'd255, 8'd0, 1'b0);
            cnt_hi1[1] += int'(o_d1[1]); cnt_hi0[1] += int'(o_d0[1]);
            dn1 += int'(o_done1[1]);     dn0 += int'(o_done0[1]);
        end
        check_int("max_hold_r1", cnt_hi1[1], 255);
        check_int("max_hold_r0", cnt_hi0[1], 255);
        check_int("max_done_r1", dn1, 1);
        check_int("max_done_r0", dn0, 1);

        // reset in the middle of GAP
        step(4'b1111, '0, 8'd1, 8'd10, 1'b0);
        step('0, '0, 8'd1, 8'd10, 1'b0);
        step('0, '0, 8'd1, 8'd10, 1'b0);
        step('0, '0, 8'd1, 8'd10, 1'b0);
        check("gap_busy_r1", {o_d1, o_busy1, o_done1}, {4'h0, 4'hf, 4'h0});
        check("gap_busy_r0", {o_d0, o_busy0, o_done0}, {4'h0, 4'hf, 4'h0});
        step('0, '0, 8'd1, 8'd10, 1'b1);
        check("reset_mid_gap_r1", {o_d1, o_busy1, o_done1}, '0);
        check("reset_mid_gap_r0", {o_d0, o_busy0, o_done0}, '0);
        step('0, '0, 8'd1, 8'd10, 1'b0);
        check("after_reset_r0", {o_d0, o_busy0, o_done0}, '0);

        // staggered triggers, i_n shortened while earlier windows are running
        for (int c = 0; c < CH; c++) begin cnt_hi1[c] = 0; cnt_hi0[c] = 0; end
        for (int i = 0; i < 16; i++) begin
            step((i < 4) ? CH'(1 << i) : '0, '0, (i < 3) ? 8'd6 : 8'd2, 8'd0, 1'b0);
            for (int c = 0; c < CH; c++) begin
                cnt_hi1[c] += int'(o_d1[c]);
                cnt_hi0[c] += int'(o_d0[c]);
            end
        end
        for (int c = 0; c < CH; c++) begin
            check_int($sformatf("stagger_ch%0d_r1", c), cnt_hi1[c], (c < 3) ? 6 : 2);
            check_int($sformatf("stagger_ch%0d_r0", c), cnt_hi0[c], (c < 3) ? 6 : 2);
        end

        // randomized traffic against the model
        rn = 8'd3; rg = 8'd1;
        for (int i = 0; i < 1500; i++) begin
            for (int c = 0; c < CH; c++) begin
                rd[c] = ($urandom_range(0, 9) < 3);
                rc[c] = ($urandom_range(0, 39) == 0);
            end
            if ($urandom_range(0, 9) == 0)
                rn = ($urandom_range(0, 9) == 0) ? CW'($urandom_range(0, 20)) : CW'($urandom_range(0, 7));
            if ($urandom_range(0, 9) == 0)
                rg = CW'($urandom_range(0, 4));
            step(rd, rc, rn, rg, ($urandom_range(0, 199) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
